mdu_sched: RTL and testbench

- Multiply/divide unit scheduler for the 5-stage MIPS pipeline. It sits in the E stage beside the ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E and runs multi-cycle operations with a countdown.
- Owns the HI/LO registers.
- Drives the stall request that freezes F/D while an MDU-dependent instruction in D cannot proceed. It is the companion of the hazard/forwarding logic.

---
 rtl/mdu_sched.sv | 191 +++++++++++++++++++
 tb/tb_mdu_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_sched
//  Description : Multiply/divide unit scheduler for the E stage of the 5-stage
//                MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, runs
//                multi-cycle operations on a countdown, owns HI/LO and raises
//                the stall request for MDU-dependent D-stage instructions.
//  Ports       : clk, reset (async, active-high)
//                start_E, mdop_E[2:0], A_E[31:0], B_E[31:0]  E-stage request
//                md_use_D                                     D-stage MDU user
//                flush (only with MDU_FLUSH_EN)               abort / drop start
//                busy, stall_md, HI[31:0], LO[31:0]
//  Options     : `define MDU_FLUSH_EN adds the flush input.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_sched #(
    parameter int MULT_CYCLES = 5,   // 1..15
    parameter int DIV_CYCLES  = 10   // 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_E,
    input  logic [2:0]  mdop_E,
    input  logic [31:0] A_E,
    input  logic [31:0] B_E,
    input  logic        md_use_D,
`ifdef MDU_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [2:0] c_op_mult  = 3'd1;
    localparam logic [2:0] c_op_multu = 3'd2;
    localparam logic [2:0] c_op_div   = 3'd3;
    localparam logic [2:0] c_op_divu  = 3'd4;
    localparam logic [2:0] c_op_mthi  = 3'd5;
    localparam logic [2:0] c_op_mtlo  = 3'd6;
    localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_op;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_flush;
    logic        w_multi_op;
    logic [31:0] w_hi_res;
    logic [31:0] w_lo_res;

`ifdef MDU_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // Multi-cycle op offered by E this cycle (MULT/MULTU/DIV/DIVU).
    assign w_multi_op = start_E && (mdop_E >= c_op_mult) && (mdop_E <= c_op_divu);

    // ------------------------------------------------------------------------
    // Result datapath, driven only from the latched operands.
    // ------------------------------------------------------------------------
    logic signed [63:0] w_a_sx;
    logic signed [63:0] w_b_sx;
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic signed [31:0] w_q_s;
    logic signed [31:0] w_r_s;
    logic        [31:0] w_q_u;
    logic        [31:0] w_r_u;
    logic               w_div_zero;
    logic               w_div_ovf;

    assign w_a_sx     = {{32{r_a[31]}}, r_a};
    assign w_b_sx     = {{32{r_b[31]}}, r_b};
    assign w_prod_s   = w_a_sx * w_b_sx;
    assign w_prod_u   = {32'd0, r_a} * {32'd0, r_b};
    assign w_q_s      = $signed(r_a) / $signed(r_b);
    assign w_r_s      = $signed(r_a) % $signed(r_b);
    assign w_q_u      = r_a / r_b;
    assign w_r_u      = r_a % r_b;
    assign w_div_zero = (r_b == 32'd0);
    // The one signed quotient that does not fit in 32 bits.
    assign w_div_ovf  = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);

    always_comb begin
        w_hi_res = r_hi;
        w_lo_res = r_lo;
        case (r_op)
            c_op_mult: begin
                w_hi_res = w_prod_s[63:32];
                w_lo_res = w_prod_s[31:0];
            end
            c_op_multu: begin
                w_hi_res = w_prod_u[63:32];
                w_lo_res = w_prod_u[31:0];
            end
            c_op_div: begin
                if (w_div_zero) begin
                    w_hi_res = r_a;
                    w_lo_res = 32'hFFFF_FFFF;
                end else if (w_div_ovf) begin
                    w_hi_res = 32'd0;
                    w_lo_res = 32'h8000_0000;
                end else begin
                    w_hi_res = w_r_s;
                    w_lo_res = w_q_s;
                end
            end
            c_op_divu: begin
                if (w_div_zero) begin
                    w_hi_res = r_a;
                    w_lo_res = 32'hFFFF_FFFF;
                end else begin
                    w_hi_res = w_r_u;
                    w_lo_res = w_q_u;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control FSM and HI/LO ownership.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 3'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else if (w_flush) begin
            // Abort in BUSY, drop any start in IDLE; HI/LO are left untouched.
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_multi_op) begin
                        r_a     <= A_E;
                        r_b     <= B_E;
                        r_op    <= mdop_E;
                        r_cnt   <= (mdop_E >= c_op_div) ? c_div_cnt : c_mult_cnt;
                        r_state <= S_BUSY;
                    end else if (start_E && (mdop_E == c_op_mthi)) begin
                        r_hi <= A_E;
                    end else if (start_E && (mdop_E == c_op_mtlo)) begin
                        r_lo <= A_E;
                    end
                end
                S_BUSY: begin
                    // New starts are ignored here; stall_md keeps them out.
                    if (r_cnt == 4'd1) begin
                        r_hi    <= w_hi_res;
                        r_lo    <= w_lo_res;
                        r_cnt   <= 4'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign busy     = (r_state == S_BUSY);
    assign stall_md = md_use_D & (busy | w_multi_op);
    assign HI       = r_hi;
    assign LO       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_sched
//  Description : Self-checking bench for mdu_sched. Expected HI/LO pairs are
//                queued when an operation is issued and compared when busy
//                falls. Define MDU_FLUSH_EN to also exercise the flush port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_sched;

    logic        clk;
    logic        reset;
    logic        start_E;
    logic [2:0]  mdop_E;
    logic [31:0] A_E;
    logic [31:0] B_E;
    logic        md_use_D;
    logic        flush;
    logic        busy;
    logic        stall_md;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] sb_q[$];   // {HI, LO}

    mdu_sched #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start_E (start_E),
        .mdop_E  (mdop_E),
        .A_E     (A_E),
        .B_E     (B_E),
        .md_use_D(md_use_D),
`ifdef MDU_FLUSH_EN
        .flush   (flush),
`endif
        .busy    (busy),
        .stall_md(stall_md),
        .HI      (HI),
        .LO      (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model built from magnitudes, independent of signed operators.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ua, ub, q, r;
        logic [63:0] p;
        ua = a[31] ? -a : a;
        ub = b[31] ? -b : b;
        case (op)
            3'd1: begin
                p = {32'd0, ua} * {32'd0, ub};
                if (a[31] ^ b[31]) p = -p;
                return p;
            end
            3'd2: return {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = ua / ub;
                r = ua % ub;
                if (a[31] ^ b[31]) q = -q;
                if (a[31]) r = -r;
                return {r, q};
            end
            3'd4: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Issue one multi-cycle op, check stall/busy timing and the queued result.
    // inj=1 drives a stray MULT start during busy cycle 3.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d, input logic [63:0] exp, input int cycles, input bit inj);
        int n;
        logic [63:0] e;
        @(negedge clk);
        start_E = 1'b1; mdop_E = op; A_E = a; B_E = b; md_use_D = use_d;
        sb_q.push_back(exp);
        #1 check_eq("stall_start", {63'd0, stall_md}, {63'd0, use_d});
        @(posedge clk); #1;
        start_E = 1'b0; mdop_E = 3'd0; A_E = $urandom; B_E = $urandom;
        n = 0;
        while (busy && n < 40) begin
            check_eq("stall_busy", {63'd0, stall_md}, {63'd0, use_d});
            if (inj && n == 2) begin
                start_E = 1'b1; mdop_E = 3'd1; A_E = 32'd3; B_E = 32'd3;
            end else begin
                start_E = 1'b0; mdop_E = 3'd0;
            end
            @(posedge clk); #1;
            n++;
        end
        start_E = 1'b0; mdop_E = 3'd0;
        check_eq("busy_cycles", 64'(n), 64'(cycles));
        check_eq("stall_after", {63'd0, stall_md}, 64'd0);
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq("hilo_result", {HI, LO}, e);
            @(posedge clk); #1;
            check_eq("hilo_stable", {HI, LO}, e);
            check_eq("busy_idle", {63'd0, busy}, 64'd0);
        end
        md_use_D = 1'b0;
    endtask

    task automatic mt_write(input logic [2:0] op, input logic [31:0] v);
        @(negedge clk);
        start_E = 1'b1; mdop_E = op; A_E = v;
        @(posedge clk); #1;
        start_E = 1'b0; mdop_E = 3'd0;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b1; start_E = 1'b0; mdop_E = 3'd0; A_E = 32'd0; B_E = 32'd0;
        md_use_D = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_hilo", {HI, LO}, 64'd0);
        @(negedge clk); reset = 1'b0;

        do_op(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, 5, 1'b0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, {32'd1, 32'hFFFF_FFFE}, 5, 1'b0);

        mt_write(3'd6, 32'h1234);
        check_eq("mtlo", {HI, LO}, {32'd1, 32'h1234});
        check_eq("mtlo_busy", {63'd0, busy}, 64'd0);
        mt_write(3'd5, 32'hCAFE);
        check_eq("mthi", {HI, LO}, {32'hCAFE, 32'h1234});
        mt_write(3'd7, 32'hDEAD);
        check_eq("op7_none", {HI, LO}, {32'hCAFE, 32'h1234});
        check_eq("op7_busy", {63'd0, busy}, 64'd0);

        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, 1'b0);
        do_op(3'd4, 32'd7, 32'd0, 1'b0, {32'd7, 32'hFFFF_FFFF}, 10, 1'b0);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'd0, 32'h8000_0000}, 10, 1'b0);
        do_op(3'd3, 32'd100, 32'hFFFF_FFF9, 1'b1, {32'd2, 32'hFFFF_FFF2}, 10, 1'b1);

        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : $urandom;
            do_op(rop, ra, rb, 1'($urandom_range(0, 1)), model(rop, ra, rb),
                  (rop >= 3'd3) ? 10 : 5, 1'b0);
        end

        // Asynchronous reset in busy cycle 4 of a DIV.
        do_op(3'd1, 32'd7, 32'd9, 1'b0, 64'd63, 5, 1'b0);
        @(negedge clk);
        md_use_D = 1'b1; start_E = 1'b1; mdop_E = 3'd3; A_E = 32'd100; B_E = 32'd7;
        @(posedge clk); #1;
        start_E = 1'b0; mdop_E = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_rst_busy", {63'd0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_busy", {63'd0, busy}, 64'd0);
        check_eq("arst_stall", {63'd0, stall_md}, 64'd0);
        check_eq("arst_hilo", {HI, LO}, 64'd0);
        @(negedge clk); reset = 1'b0; md_use_D = 1'b0;

`ifdef MDU_FLUSH_EN
        mt_write(3'd5, 32'hAAAA);
        mt_write(3'd6, 32'h5555);
        @(negedge clk);
        start_E = 1'b1; mdop_E = 3'd3; A_E = 32'd100; B_E = 32'd7;
        @(posedge clk); #1;
        start_E = 1'b0; mdop_E = 3'd0;
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_busy", {63'd0, busy}, 64'd0);
        check_eq("flush_hilo", {HI, LO}, {32'hAAAA, 32'h5555});
        @(negedge clk);
        flush = 1'b1; start_E = 1'b1; mdop_E = 3'd5; A_E = 32'hBEEF;
        @(posedge clk); #1;
        flush = 1'b0; start_E = 1'b0; mdop_E = 3'd0;
        check_eq("flush_mthi", {HI, LO}, {32'hAAAA, 32'h5555});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
